adder_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 24-bit `adder` instance between NUM_REQ requesters.
- Each requester issues add/sub operations over a valid/ready handshake.
- The block registers operands, drives the shared adder, captures result and flags, and returns them with the requester ID over a valid/ready response channel.
- Sits in the microarchitecture between ALU-side clients (address generation, loop counters, vector lanes) and the single adder.

---
 rtl/adder_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder arbiter.
package adder_arb_pkg;

    localparam int unsigned ADD_W = 24;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = ID_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (en && !any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external adder between NUM_REQ requesters.
// Optional per-requester grant counters are enabled with ADDER_ARB_STATS_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned N       = ADD_W,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_sub,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_r,
    input  logic                 add_c,
    input  logic                 add_neg,
    input  logic                 add_v,
    input  logic                 add_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N-1:0]         rsp_r,
    output logic [3:0]           rsp_flags
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    state_e state_q, state_d;

    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [N-1:0]       a_q, b_q;
    logic               sub_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [N-1:0]       rsp_r_q;
    logic [3:0]         rsp_flags_q;

    logic               grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [N-1:0]       sel_a, sel_b;
    logic               sel_sub;
    logic [3:0]         flags_in;

    // A new op can only start when the result slot is free or draining this cycle.
    assign grant_en = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_a   = req_a[i*N +: N];
                sel_b   = req_b[i*N +: N];
                sel_sub = req_sub[i];
            end
        end
    end

    always_comb begin
        flags_in         = '0;
        flags_in[FLAG_N] = add_neg;
        flags_in[FLAG_Z] = add_z;
        flags_in[FLAG_C] = add_c;
        flags_in[FLAG_V] = add_v;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = gnt_any ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                a_q      <= sel_a;
                b_q      <= sel_b;
                sub_q    <= sel_sub;
                id_q     <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_r_q     <= add_r;
                rsp_flags_q <= flags_in;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = sub_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_flags = rsp_flags_q;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // A grant coinciding with stat_clr restarts that counter at one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (gnt[i]) begin
                if (stat_clr) begin
                    cnt_q[i] <= 16'd1;
                end else if (cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end else if (stat_clr) begin
                cnt_q[i] <= '0;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule
